// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subs.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subs (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = a_i ^ b_i ^ bin_i;
  assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_BORROW_IN_EN to add a borrow_in port for multi-word chaining.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic [WIDTH-1:0] res_sr_d;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_init;
  logic             cell_d;
  logic             cell_bo;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  assign borrow_init = borrow_in;
`else
  assign borrow_init = 1'b0;
`endif

  full_subs u_cell (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .bin_i (brw_q),
    .d_o   (cell_d),
    .bo_o  (cell_bo)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 holds the LSB.
  assign res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            brw_q   <= borrow_init;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_sr_d;
          brw_q    <= cell_bo;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            diff_q   <= res_sr_d;
            borrow_q <= cell_bo;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands against an arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  logic             borrow_in;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] hold_diff;
  logic             hold_borrow;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    .borrow_in (borrow_in),
`endif
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow    (borrow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_bin(input logic v);
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    borrow_in = v;
`else
    if (v) $display("note: borrow_in requested without port, ignored");
`endif
  endtask

  // Runs one subtraction from an IDLE cycle; optionally re-pulses start mid-SHIFT.
  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input logic op_bin, input bit restart_mid, output int done_cyc);
    int   exp_d;
    logic exp_bo;
    exp_d  = (int'(op_a) - int'(op_b) - int'(op_bin)) & ((1 << WIDTH) - 1);
    exp_bo = (int'(op_a) < (int'(op_b) + int'(op_bin)));
    a = op_a;
    b = op_b;
    set_bin(op_bin);
    start = 1'b1;
    step();
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    set_bin(1'($urandom));
    for (int i = 0; i < WIDTH; i++) begin
      check_eq("busy_shift", 32'(busy), 32'd1);
      check_eq("done_shift", 32'(done), 32'd0);
      check_eq("diff_hold_shift", 32'(diff), 32'(hold_diff));
      check_eq("borrow_hold_shift", 32'(borrow), 32'(hold_borrow));
      start = (restart_mid && i == 3) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_done", 32'(busy), 32'd0);
    check_eq("diff", 32'(diff), 32'(exp_d));
    check_eq("borrow", 32'(borrow), 32'(exp_bo));
    done_cyc    = cyc;
    hold_diff   = WIDTH'(exp_d);
    hold_borrow = exp_bo;
    $display("op a=%0d b=%0d bin=%0d restart=%0d -> diff=%0d borrow=%0d (exp %0d/%0d)",
             op_a, op_b, op_bin, restart_mid, diff, borrow, exp_d, exp_bo);
    step();
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int d1;
    int d2;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    set_bin(1'b0);
    hold_diff   = '0;
    hold_borrow = 1'b0;
    step();
    step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_borrow", 32'(borrow), 32'd0);

    // rst and start together: rst wins.
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check_eq("rst_over_start", 32'(busy), 32'd0);
    step();
    check_eq("no_start_after_rst", 32'(busy), 32'd0);

    run_op(8'd100, 8'd58, 1'b0, 1'b0, d1);

    run_op(8'd5, 8'd9, 1'b0, 1'b0, d1);
    for (int i = 0; i < 20; i++) begin
      check_eq("hold_diff_idle", 32'(diff), 32'(hold_diff));
      check_eq("hold_borrow_idle", 32'(borrow), 32'(hold_borrow));
      check_eq("hold_done_idle", 32'(done), 32'd0);
      step();
    end

    // Back-to-back: second start lands in the first IDLE cycle.
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, d1);
    run_op(8'h00, 8'h01, 1'b0, 1'b0, d2);
    check_eq("b2b_spacing", 32'(d2 - d1), 32'd10);

    // start re-pulsed mid-SHIFT is ignored.
    run_op(8'd200, 8'd17, 1'b0, 1'b1, d1);
    for (int i = 0; i < 12; i++) begin
      check_eq("no_second_done", 32'(done), 32'd0);
      check_eq("no_restart_busy", 32'(busy), 32'd0);
      step();
    end

    // Reset during the 4th SHIFT cycle aborts without a done pulse.
    a     = 8'd77;
    b     = 8'd33;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check_eq("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold_diff   = '0;
    hold_borrow = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_diff", 32'(diff), 32'd0);
    check_eq("abort_borrow", 32'(borrow), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check_eq("abort_no_done", 32'(done), 32'd0);
      step();
    end
    run_op(8'd100, 8'd58, 1'b0, 1'b0, d1);

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    run_op(8'd10, 8'd3, 1'b1, 1'b0, d1);
    run_op(8'd0, 8'd0, 1'b1, 1'b0, d1);
`endif

    for (int n = 0; n < 30; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rbin;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 5 == 0) rb = ra;
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
      rbin = 1'($urandom);
`else
      rbin = 1'b0;
`endif
      run_op(ra, rb, rbin, 1'($urandom_range(0, 3) == 0), d1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
